div_mult_unit: RTL and testbench

- Iterative signed multiply/divide unit that receives start requests from the multicycle control unit.
- Returns a 64-bit result split into HI/LO, which the CPU latches into its regHI/regLO registers.
- Flags division by zero so the control unit can raise its ZeroException.
- The control unit is the initiator; this block is the responder.

---
 rtl/div_mult_if.sv | 25 ++
 rtl/div_mult_unit.sv | 152 +++++++++++++++
 tb/tb_div_mult_unit.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/div_mult_if.sv
// Start/result handshake between the multicycle control unit and the multiply/divide unit.
// The control unit is the master and drives the request; the unit is the slave and returns results.
interface div_mult_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             zero_exception;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, zero_exception, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, zero_exception, hi, lo
  );
endinterface

// File: rtl/div_mult_unit.sv
// Iterative signed multiply (shift-add) / divide (restoring) unit on operand magnitudes,
// with sign correction at the end; results land in registered HI/LO.
module div_mult_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic       clk,
  input  logic       reset,
  div_mult_if.slave  bus
);
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned AW = 2 * WIDTH + 1;

  typedef enum logic [1:0] {IDLE, CHECK, RUN, FINISH} state_e;

  state_e           state_q, state_d;
  logic             op_q, op_d;
  logic             neg_a_q, neg_a_d;
  logic             neg_x_q, neg_x_d;
  logic [WIDTH-1:0] mag_a_q, mag_a_d;
  logic [WIDTH-1:0] mag_b_q, mag_b_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             zexc_q, zexc_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  // One iteration step for each operation, plus final sign correction.
  // acc_q holds {carry, upper, multiplier} for mult and {rem(WIDTH+1), quot} for div.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_a_q} : '0);
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, mag_b_q};
    prod_fix  = neg_x_q ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
    quot_fix  = neg_x_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix   = neg_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  // Next-state and output logic; busy/done/zero_exception are registered one cycle behind the state.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    neg_a_d = neg_a_q;
    neg_x_d = neg_x_q;
    mag_a_d = mag_a_q;
    mag_b_d = mag_b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    zexc_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_d    = bus.op;
          neg_a_d = bus.a[WIDTH-1];
          neg_x_d = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
          mag_a_d = bus.a[WIDTH-1] ? -bus.a : bus.a;
          mag_b_d = bus.b[WIDTH-1] ? -bus.b : bus.b;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (op_q && (mag_b_q == '0)) begin
          zexc_d  = 1'b1;
          state_d = IDLE;
        end else begin
          acc_d   = op_q ? {{(WIDTH+1){1'b0}}, mag_a_q} : {{(WIDTH+1){1'b0}}, mag_b_q};
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        busy_d = 1'b1;
        if (!op_q) begin
          acc_d = {1'b0, mul_sum, acc_q[WIDTH-1:1]};
        end else if (!div_diff[WIDTH]) begin
          acc_d = {div_diff, acc_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = {div_shift, acc_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        busy_d  = 1'b1;
        done_d  = 1'b1;
        state_d = IDLE;
        if (!op_q) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q    <= 1'b0;
      neg_a_q <= 1'b0;
      neg_x_q <= 1'b0;
      mag_a_q <= '0;
      mag_b_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      zexc_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      neg_a_q <= neg_a_d;
      neg_x_q <= neg_x_d;
      mag_a_q <= mag_a_d;
      mag_b_q <= mag_b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      zexc_q  <= zexc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.zero_exception = zexc_q;
  assign bus.hi             = hi_q;
  assign bus.lo             = lo_q;
endmodule

// File: tb/tb_div_mult_unit.sv
// Bench for div_mult_unit: a cycle-level reference built on 64-bit signed arithmetic checks every
// output each cycle; directed cases pin known results, then a long randomized run follows.
module tb_div_mult_unit;
  localparam int unsigned W = 32;
  localparam int unsigned DONE_K = W + 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  div_mult_if #(.WIDTH(W)) bus ();
  div_mult_unit #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result from plain signed arithmetic; '/' and '%' truncate toward zero.
  function automatic void model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic dz, output logic [W-1:0] rh, output logic [W-1:0] rl);
    longint sa, sb, p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 1'b0; rh = '0; rl = '0;
    if (!op) begin
      p = sa * sb;
      rh = p[63:32]; rl = p[31:0];
    end else if (sb == 0) begin
      dz = 1'b1;
    end else begin
      q = sa / sb; r = sa % sb;
      rh = r[31:0]; rl = q[31:0];
    end
  endfunction

  // Timeline model: k counts edges since the accepting edge; busy covers k=1..DONE_K, done at DONE_K.
  logic           m_active = 1'b0, m_dz = 1'b0;
  int             m_k = 0;
  logic [W-1:0]   m_hi = '0, m_lo = '0, r_hi = '0, r_lo = '0;
  logic           e_busy = 1'b0, e_done = 1'b0, e_z = 1'b0;
  int             done_count = 0;

  initial begin : monitor
    logic s_rst, s_start, s_op;
    logic [W-1:0] s_a, s_b;
    forever begin
      @(posedge clk);
      s_rst = reset; s_start = bus.start; s_op = bus.op; s_a = bus.a; s_b = bus.b;
      e_busy = 1'b0; e_done = 1'b0; e_z = 1'b0;
      if (!s_rst) begin
        m_active = 1'b0; m_hi = '0; m_lo = '0;
      end else if (m_active) begin
        m_k++;
        if (m_dz) begin
          if (m_k == 1) begin e_z = 1'b1; m_active = 1'b0; end
        end else begin
          e_busy = 1'b1;
          if (m_k == DONE_K) begin
            e_done = 1'b1; m_hi = r_hi; m_lo = r_lo; m_active = 1'b0;
          end
        end
      end else if (s_start) begin
        model(s_op, s_a, s_b, m_dz, r_hi, r_lo);
        m_active = 1'b1; m_k = 0;
      end
      #1;
      if (bus.done === 1'b1) done_count++;
      check("busy", 64'(bus.busy), 64'(e_busy));
      check("done", 64'(bus.done), 64'(e_done));
      check("zero_exception", 64'(bus.zero_exception), 64'(e_z));
      check("hi", 64'(bus.hi), 64'(m_hi));
      check("lo", 64'(bus.lo), 64'(m_lo));
    end
  end

  // Issue one request, scramble the inputs afterwards, then check the literal outcome.
  task automatic run_op(input string name, input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ez, input logic [W-1:0] eh, input logic [W-1:0] el);
    logic seen, was_z;
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.start = 1'b0; bus.op = 1'($urandom); bus.a = $urandom; bus.b = $urandom;
    seen = 1'b0; was_z = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1 || bus.zero_exception === 1'b1) begin
        seen = 1'b1; was_z = bus.zero_exception;
      end
    end
    check({name, " completes"}, 64'(seen), 64'(1));
    check({name, " zexc"}, 64'(was_z), 64'(ez));
    check({name, " hi"}, 64'(bus.hi), 64'(eh));
    check({name, " lo"}, 64'(bus.lo), 64'(el));
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(7))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h0000_0001;
      4: return 32'($urandom_range(200)) - 32'd100;
      default: return $urandom;
    endcase
  endfunction

  initial begin : driver
    int dones_before;
    bus.start = 1'b0; bus.op = 1'b0; bus.a = '0; bus.b = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    run_op("mul 7*-3",   1'b0, 32'd7,          32'hFFFF_FFFD, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("mul min*min", 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h4000_0000, 32'h0000_0000);
    run_op("div -7/2",   1'b1, 32'hFFFF_FFF9,  32'd2,         1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div 100/7",  1'b1, 32'd100,        32'd7,         1'b0, 32'd2,         32'd14);
    run_op("div 5/0",    1'b1, 32'd5,          32'd0,         1'b1, 32'd2,         32'd14);
    run_op("div min/-1", 1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 1'b0, 32'd0,         32'h8000_0000);

    // Starts at cycles 5 and 20 of a running mult must be dropped.
    dones_before = done_count;
    @(negedge clk); bus.start = 1'b1; bus.op = 1'b0; bus.a = 32'd123; bus.b = 32'hFFFF_FFD3;
    @(negedge clk); bus.start = 1'b0;
    repeat (4) @(negedge clk);
    bus.start = 1'b1; bus.a = 32'd1; bus.b = 32'd1;
    @(negedge clk); bus.start = 1'b0;
    repeat (14) @(negedge clk);
    bus.start = 1'b1; bus.op = 1'b1; bus.b = 32'd0;
    @(negedge clk); bus.start = 1'b0;
    repeat (40) @(negedge clk);
    check("ignored starts single done", 64'(done_count - dones_before), 64'(1));
    check("ignored starts hi", 64'(bus.hi), 64'(32'hFFFF_FFFF));
    check("ignored starts lo", 64'(bus.lo), 64'(32'hFFFF_EA61));

    // Abort at RUN count 10; outputs must clear without waiting for an edge.
    dones_before = done_count;
    @(negedge clk); bus.start = 1'b1; bus.op = 1'b0; bus.a = 32'd1000; bus.b = 32'd1000;
    @(negedge clk); bus.start = 1'b0;
    repeat (11) @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort busy", 64'(bus.busy), 64'(0));
    check("abort hi", 64'(bus.hi), 64'(0));
    check("abort lo", 64'(bus.lo), 64'(0));
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    check("abort no done", 64'(done_count - dones_before), 64'(0));
    run_op("div 9/3", 1'b1, 32'd9, 32'd3, 1'b0, 32'd0, 32'd3);

    // Randomized traffic, including starts while busy and divide-by-zero.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      bus.start = ($urandom_range(9) == 0);
      bus.op = 1'($urandom);
      bus.a = pick();
      bus.b = ($urandom_range(7) == 0) ? 32'd0 : pick();
    end
    @(negedge clk); bus.start = 1'b0;
    repeat (40) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
